// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default oversampling.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DATA_BITS          = 8;
   localparam int unsigned OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, framing/overrun flags and optional even parity.
// Define UART_RX_PARITY_EN to add the PARITY state and the parity_err output.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 rx_clk_en,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rdy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM; a completing byte is assigned after the acknowledge so that set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         if (rdy_clr) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end
         if (rx_clk_en) begin
            case (state)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state    <= ST_START;
                     tick_cnt <= '0;
                     rx_busy  <= 1'b1;
                  end
               end
               ST_START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     if (!rx_s) begin
                        state <= ST_DATA;
                     end else begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               ST_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt  <= '0;
                     shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     bit_cnt   <= bit_cnt + BIT_W'(1);
                     if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     par_bit  <= rx_s;
                     state    <= ST_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
`endif
               ST_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     state    <= ST_IDLE;
                     rx_busy  <= 1'b0;
                     if (rx_s) begin
                        data_out  <= shift_reg;
                        rdy       <= 1'b1;
                        frame_err <= 1'b0;
                        if (rdy) begin
                           overrun <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit must hold an even count of ones.
                        parity_err <= (^shift_reg) ^ par_bit;
`endif
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expectations are queued per frame and checked when rx_busy falls.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;
   import uart_pkg::*;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       rx        = 1'b1;
   logic       rx_clk_en = 1'b1;
   logic       rdy_clr   = 1'b0;
   logic [7:0] data_out;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   always #5 clk = ~clk;

   uart_receiver #(.OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_clk_en (rx_clk_en),
      .rdy_clr   (rdy_clr),
      .data_out  (data_out),
      .rdy       (rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   typedef struct packed {
      logic [7:0] data;
      logic       rdy;
      logic       fe;
      logic       ov;
      logic       pe;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model of the visible output registers
   logic [7:0] m_data = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_fe   = 1'b0;
   logic       m_ov   = 1'b0;
   logic       m_pe   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_model();
      exp_t e;
      e.data = m_data;
      e.rdy  = m_rdy;
      e.fe   = m_fe;
      e.ov   = m_ov;
      e.pe   = m_pe;
      sb.push_back(e);
   endtask

   task automatic expect_frame(input logic [7:0] b, input logic stop_bit, input logic par);
      if (stop_bit) begin
         if (m_rdy) m_ov = 1'b1;
         m_data = b;
         m_rdy  = 1'b1;
         m_fe   = 1'b0;
         m_pe   = (^b) ^ par;
         push_model();
      end else begin
         m_fe = 1'b1;
         push_model();
         // The low stop bit is still seen in IDLE and rejected later as a glitch.
         push_model();
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`endif
      drive_bit(stop_bit);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      rdy_clr = 1'b1;
      @(negedge clk);
      rdy_clr = 1'b0;
      m_rdy = 1'b0;
      m_ov  = 1'b0;
      check_eq("rdy_after_clr", rdy, m_rdy);
      check_eq("overrun_after_clr", overrun, m_ov);
   endtask

   // Monitor: every end of activity (rx_busy falling) consumes one expectation
   logic busy_q = 1'b0;
   always @(negedge clk) begin
      if (busy_q && !rx_busy) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            mon_e = sb.pop_front();
            check_eq("data_out", data_out, mon_e.data);
            check_eq("rdy", rdy, mon_e.rdy);
            check_eq("frame_err", frame_err, mon_e.fe);
            check_eq("overrun", overrun, mon_e.ov);
`ifdef UART_RX_PARITY_EN
            check_eq("parity_err", parity_err, mon_e.pe);
`endif
         end
      end
      busy_q <= rx_busy;
   end

   initial begin
      rst = 1'b1;
      idle(4);
      check_eq("rst_data_out", data_out, 8'h00);
      check_eq("rst_rdy", rdy, 1'b0);
      check_eq("rst_frame_err", frame_err, 1'b0);
      check_eq("rst_overrun", overrun, 1'b0);
      check_eq("rst_rx_busy", rx_busy, 1'b0);
      rst = 1'b0;
      idle(20);

      // Good frame, then acknowledge
      expect_frame(8'hA5, 1'b1, ^8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5);
      idle(32);
      pulse_clr();
      check_eq("hold_data_after_clr", data_out, m_data);

      // Short low pulse on an idle line is rejected
      push_model();
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(32);
      check_eq("glitch_rx_busy", rx_busy, 1'b0);
      check_eq("glitch_rdy", rdy, 1'b0);

      // Framing error keeps previous byte
      expect_frame(8'h3C, 1'b0, ^8'h3C);
      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle(48);

      // Back-to-back frames without acknowledge
      expect_frame(8'h11, 1'b1, ^8'h11);
      expect_frame(8'h22, 1'b1, ^8'h22);
      send_frame(8'h11, 1'b1, ^8'h11);
      send_frame(8'h22, 1'b1, ^8'h22);
      idle(32);
      check_eq("b2b_data_out", data_out, 8'h22);
      check_eq("b2b_overrun", overrun, 1'b1);
      pulse_clr();

      // Reset in the middle of data bit 3 of 0xF0
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b0;
      idle(8);
      m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
      push_model();
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check_eq("midrst_data_out", data_out, 8'h00);
      check_eq("midrst_rdy", rdy, 1'b0);
      check_eq("midrst_frame_err", frame_err, 1'b0);
      check_eq("midrst_rx_busy", rx_busy, 1'b0);
      rst = 1'b0;
      idle(32);
      expect_frame(8'h0F, 1'b1, ^8'h0F);
      send_frame(8'h0F, 1'b1, ^8'h0F);
      idle(32);

`ifdef UART_RX_PARITY_EN
      pulse_clr();
      expect_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(32);
      check_eq("par_bad_flag", parity_err, 1'b1);
      pulse_clr();
      expect_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(32);
      check_eq("par_good_flag", parity_err, 1'b0);
`endif

      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
      check_eq("sb_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-004 SHALL have port rx_clk_en, input, 1 bit: one-clk-wide sample tick at 16x the baud rate.
REQ-005 SHALL have port rdy_clr, input, 1 bit: consumer acknowledge; clears rdy.
REQ-006 SHALL have port data_out, output, 8 bits: last correctly framed byte.
REQ-007 SHALL have port rdy, output, 1 bit: new byte available in data_out.
REQ-008 SHALL have port frame_err, output, 1 bit: last frame had a low stop bit.
REQ-009 SHALL have port overrun, output, 1 bit: a byte completed while rdy was still set.
REQ-010 SHALL have port rx_busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have parameter OVERSAMPLE, default 16: ticks per bit.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP; the tick counter and bit counter SHALL advance only on rx_clk_en.
REQ-014 SHALL leave IDLE for START, with the tick counter at 0, on the first rx_clk_en that sees the synchronized rx low.
REQ-015 SHALL, in START at tick count 7 (mid-bit), go to DATA with counters cleared if rx is low; otherwise it SHALL return to IDLE as a glitch, with no output change.
REQ-016 SHALL, in DATA, sample rx at tick count 15 (mid-bit), shifting LSB first; after bit 7 it SHALL go to PARITY or STOP.
REQ-017 SHALL, in STOP at tick count 15 with rx high: load data_out from the shift register, set rdy, clear frame_err, and go to IDLE.
REQ-018 SHALL, in STOP at tick count 15 with rx low: hold data_out and rdy, set frame_err, and go to IDLE.
REQ-019 SHALL assert rdy on the clk edge that samples a valid stop bit; there is no further latency.
REQ-020 SHALL clear rdy when rdy_clr is high; if rdy_clr coincides with a new byte completing, set SHALL win.
REQ-021 SHALL set overrun, sticky, when a valid byte completes while rdy=1; data_out SHALL take the new byte; rdy_clr SHALL clear overrun.
REQ-022 SHALL ignore rx_clk_en-free cycles; all counters SHALL hold.

Reset
REQ-023 SHALL, while rst=1: state=IDLE, both counters=0, shift register=0, both synchronizer flops=1, data_out=0, rdy=0, frame_err=0, overrun=0, parity_err=0.
REQ-024 SHALL have rst override every other input, including mid-frame; the partial byte SHALL be discarded.

Configuration
REQ-025 SHALL, with macro UART_RX_PARITY_EN defined: add output parity_err (1 bit) and insert state PARITY after DATA, sampling an even-parity bit at tick 15.
REQ-026 SHALL set parity_err on the STOP completion if the sampled parity mismatches; otherwise it SHALL clear parity_err on that completion; rdy SHALL still be set.
REQ-027 SHALL, without UART_RX_PARITY_EN: have no parity_err port and no PARITY state; the frame SHALL be 10 bits.

Structure
REQ-028 SHALL place the state enum typedef, DATA_BITS=8 and the default OVERSAMPLE in shared package uart_pkg, for reuse by uart_transmitter.
REQ-029 SHALL instantiate one sub-module, uart_rx_sync (2-flop synchronizer, reset value 1).

Verification (rx_clk_en every clk; 16 clk per bit)
REQ-030 SHALL cover: serial frame 0xA5 with stop=1 -> data_out=0xA5, rdy=1, frame_err=0; then rdy_clr pulse -> rdy=0 next clk.
REQ-031 SHALL cover: rx low for 4 ticks, then high -> return to IDLE, rx_busy back to 0, rdy stays 0.
REQ-032 SHALL cover: frame 0x3C with stop=0 after a prior 0xA5 -> frame_err=1, data_out stays 0xA5, rdy unchanged.
REQ-033 SHALL cover: back-to-back frames 0x11 then 0x22 with no rdy_clr -> data_out=0x22, rdy=1, overrun=1.
REQ-034 SHALL cover: rst pulsed during data bit 3 of 0xF0 -> all outputs at reset values next clk; a following frame 0x0F is received correctly.
REQ-035 SHALL cover, with UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1, rdy=1; with parity bit 1 -> parity_err=0.
